buf_capture_window: RTL and testbench
=====================================

# buf_capture_window

Capture-window gate between the AXI4-Stream readout feeds (buf0..buf3 in the aclk domain, 128-bit) and the readout-buffer S_AXIS inputs. On a capture request it optionally aligns to the next SYSREF rising edge, skips a programmable number of beats, then forwards exactly NBEATS input beats with tlast on the final one. Outside the window, input data is discarded. One instance sits in each of the four buffer paths.

## Interface
- NBEATS, 2048: beats per capture window; legal range 1..65535.
- SYNC_SYSREF, "TRUE": "TRUE" waits for a SYSREF rising edge after capture; "FALSE" starts on the cycle after capture.
- aclk  in  1  stream clock; the only clock.
- areset  in  1  asynchronous, active-high reset.
- capture_i  in  1  single-cycle capture request, already synchronous to aclk.
- sysref_i  in  1  registered SYSREF level, synchronous to aclk.
- delay_i  in  16  number of valid beats to skip after alignment; latched on accepted capture.
- s_axis_tdata  in  128  input samples.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  constant 1; upstream is never stalled.
- m_axis_tdata  out  128  output samples, registered.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  marks the final window beat.
- busy_o  out  1  high when state is not IDLE, or while m_axis_tvalid is high.
- overflow_o  out  1  sticky: a window beat was dropped; cleared on the next accepted capture.
- count_o  out  16  beats accepted downstream since the last accepted capture.

## Operation
- States and transitions:
  - IDLE, capture_i = 1: go to ARM if SYNC_SYSREF = "TRUE". Otherwise go to DELAY, or to RUN if delay_i = 0.
  - ARM: wait for sysref edge. On the edge, go to DELAY, or to RUN if the latched delay = 0.
  - DELAY: count valid input beats up to the latched delay, then go to RUN.
  - RUN: count valid input beats; on the NBEATS-th, return to IDLE.
- On an accepted capture (IDLE only): latch delay_i, clear count_o, clear overflow_o.
- capture_i outside IDLE is ignored, with no side effects.
- SYSREF edge detection:
  - sysref_q is a 1-cycle registered copy of sysref_i; edge = sysref_i & ~sysref_q.
  - sysref_q is tracked in all states, so an edge in the capture cycle itself does not count; alignment needs an edge strictly after capture.
- Beat eligibility:
  - The beat present in the transition cycle out of IDLE or ARM is not counted.
  - Counting begins with the following cycle's beat.
- Output register (one entry):
  - A RUN beat loads the register when it is empty or being accepted that cycle (m_axis_tvalid & m_axis_tready).
  - tlast is set when the beat is the NBEATS-th.
- Drop rule:
  - Applies when the register holds an unaccepted beat and a new RUN beat arrives.
  - The new beat is dropped and overflow_o is set.
  - The window counter still advances, so the window is defined in input beats.
  - If the dropped beat was the final beat, tlast is ORed into the held beat.
- count_o increments on each m_axis handshake and saturates at 65535.

## Timing
- Reset values: state IDLE, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, busy_o 0, overflow_o 0, count_o 0, sysref_q 0, s_axis_tready 1.
- Latency: an input beat accepted in RUN at cycle n appears on m_axis at cycle n+1.
- m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid & ~m_axis_tready.
- busy_o rises the cycle after the accepted capture. It falls the cycle after the final beat's handshake, or the cycle after the state returns to IDLE with the register empty.
- Reset mid-window: all state clears immediately. Asynchronous assertion; synchronous deassertion is the integrator's responsibility. No partial tlast is emitted.
- Invalid input cycles (s_axis_tvalid = 0) do not advance DELAY or RUN counters.

## Test plan
- SYNC_SYSREF="FALSE", NBEATS=4, delay 0, tvalid and tready constantly 1, data = beat index. Capture at cycle 10 → m_axis carries input beats 11..14 at cycles 12..15, tlast at cycle 15, count_o = 4, busy_o falls at cycle 16.
- SYNC_SYSREF="TRUE", delay 3. Capture at cycle 10 with a sysref edge at cycle 10, and a second edge at cycle 40 → the cycle-10 edge is ignored; first forwarded beat is the cycle-44 input.
- During RUN, hold m_axis_tready = 0 for 3 cycles → 2 beats dropped, overflow_o = 1, window still ends after NBEATS input beats, count_o = NBEATS-2.
- Drop the final beat with tready low → held beat exits with tlast = 1; exactly one tlast per window.
- capture_i re-pulsed during DELAY and RUN → ignored; delay and count unaffected. A capture after IDLE clears overflow_o and count_o.
- Assert areset mid-RUN → all outputs return to their reset values immediately. The next capture produces a full NBEATS window.

Source files
------------

// File: rtl/buf_capture_window.sv
`default_nettype none
// ============================================================================
// Module      : buf_capture_window
// Description : Capture-window gate for one readout-buffer path. On a capture
//               request it optionally aligns to the next SYSREF rising edge,
//               skips a programmable number of valid beats, then forwards
//               exactly NBEATS input beats with tlast on the final one.
//               Beats outside the window are discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module buf_capture_window #(
   parameter int    NBEATS      = 2048,
   parameter string SYNC_SYSREF = "TRUE"
) (
   input  logic         aclk,
   input  logic         areset,
   input  logic         capture_i,
   input  logic         sysref_i,
   input  logic [15:0]  delay_i,
   input  logic [127:0] s_axis_tdata,
   input  logic         s_axis_tvalid,
   output logic         s_axis_tready,
   output logic [127:0] m_axis_tdata,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic         m_axis_tlast,
   output logic         busy_o,
   output logic         overflow_o,
   output logic [15:0]  count_o
);

   localparam logic [1:0]  c_st_idle  = 2'd0;
   localparam logic [1:0]  c_st_arm   = 2'd1;
   localparam logic [1:0]  c_st_delay = 2'd2;
   localparam logic [1:0]  c_st_run   = 2'd3;

   localparam bit          c_sync     = (SYNC_SYSREF == "TRUE");
   localparam logic [15:0] c_last_idx = 16'(NBEATS - 1);

   logic [1:0]   r_state;
   logic         r_sysref_q;
   logic [15:0]  r_delay;
   logic [15:0]  r_beat_cnt;
   logic [127:0] r_tdata;
   logic         r_tvalid;
   logic         r_tlast;
   logic         r_overflow;
   logic [15:0]  r_count;

   logic         w_edge;
   logic         w_capture;
   logic         w_delay_done;
   logic         w_run_beat;
   logic         w_final;
   logic         w_accept;
   logic         w_load;
   logic         w_drop;

   // Only the cycle-to-cycle rise of the registered SYSREF level counts as an edge.
   assign w_edge       = sysref_i & ~r_sysref_q;
   assign w_capture    = capture_i & (r_state == c_st_idle);
   assign w_delay_done = (r_beat_cnt == (r_delay - 16'd1));
   assign w_run_beat   = (r_state == c_st_run) & s_axis_tvalid;
   assign w_final      = w_run_beat & (r_beat_cnt == c_last_idx);
   assign w_accept     = r_tvalid & m_axis_tready;
   // A window beat lands in the register if it is empty or draining this cycle;
   // otherwise it is dropped but still consumes a window slot.
   assign w_load       = w_run_beat & (~r_tvalid | m_axis_tready);
   assign w_drop       = w_run_beat & r_tvalid & ~m_axis_tready;

   assign s_axis_tready = 1'b1;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign busy_o        = (r_state != c_st_idle) | r_tvalid;
   assign overflow_o    = r_overflow;
   assign count_o       = r_count;

   // SYSREF history is kept in every state so an edge coincident with capture is not seen later.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_sysref_q <= 1'b0;
      end else begin
         r_sysref_q <= sysref_i;
      end
   end

   // Window sequencer: alignment, delay skip and beat counting over valid input beats.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state    <= c_st_idle;
         r_delay    <= 16'd0;
         r_beat_cnt <= 16'd0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (capture_i) begin
                  r_delay    <= delay_i;
                  r_beat_cnt <= 16'd0;
                  if (c_sync) begin
                     r_state <= c_st_arm;
                  end else if (delay_i == 16'd0) begin
                     r_state <= c_st_run;
                  end else begin
                     r_state <= c_st_delay;
                  end
               end
            end
            c_st_arm: begin
               if (w_edge) begin
                  r_beat_cnt <= 16'd0;
                  r_state    <= (r_delay == 16'd0) ? c_st_run : c_st_delay;
               end
            end
            c_st_delay: begin
               if (s_axis_tvalid) begin
                  if (w_delay_done) begin
                     r_beat_cnt <= 16'd0;
                     r_state    <= c_st_run;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 16'd1;
                  end
               end
            end
            c_st_run: begin
               if (s_axis_tvalid) begin
                  if (w_final) begin
                     r_beat_cnt <= 16'd0;
                     r_state    <= c_st_idle;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 16'd1;
                  end
               end
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   // Single-entry output register; a dropped final beat folds its tlast into the held beat.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_tdata  <= 128'd0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end else if (w_load) begin
         r_tdata  <= s_axis_tdata;
         r_tvalid <= 1'b1;
         r_tlast  <= w_final;
      end else begin
         if (w_accept) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
         end
         if (w_drop && w_final) begin
            r_tlast <= 1'b1;
         end
      end
   end

   // Sticky overflow flag and saturating handshake counter, both reset by an accepted capture.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_overflow <= 1'b0;
         r_count    <= 16'd0;
      end else if (w_capture) begin
         r_overflow <= 1'b0;
         r_count    <= 16'd0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_accept && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_buf_capture_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_buf_capture_window
// Description : Scoreboard bench for buf_capture_window. Instance A runs
//               without SYSREF alignment, instance B with it (both NBEATS=4).
//               Input data equals the cycle number, so each expected beat is
//               recorded as (handshake cycle, data, tlast).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buf_capture_window;

   typedef struct {
      int          cyc;
      logic [127:0] data;
      logic        last;
   } exp_t;

   logic         clk;
   logic         areset;
   logic [127:0] s_tdata;
   logic         s_tvalid;

   logic         capture_a, ready_a;
   logic [15:0]  delay_a;
   logic         a_s_tready, a_m_tvalid, a_m_tlast, a_busy, a_overflow;
   logic [127:0] a_m_tdata;
   logic [15:0]  a_count;

   logic         capture_b, ready_b, sysref_b;
   logic [15:0]  delay_b;
   logic         b_s_tready, b_m_tvalid, b_m_tlast, b_busy, b_overflow;
   logic [127:0] b_m_tdata;
   logic [15:0]  b_count;

   int   cyc;
   int   checks;
   int   errors;
   exp_t qa[$];
   exp_t qb[$];

   buf_capture_window #(.NBEATS(4), .SYNC_SYSREF("FALSE")) u_dut_a (
      .aclk          (clk),
      .areset        (areset),
      .capture_i     (capture_a),
      .sysref_i      (sysref_b),
      .delay_i       (delay_a),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (a_s_tready),
      .m_axis_tdata  (a_m_tdata),
      .m_axis_tvalid (a_m_tvalid),
      .m_axis_tready (ready_a),
      .m_axis_tlast  (a_m_tlast),
      .busy_o        (a_busy),
      .overflow_o    (a_overflow),
      .count_o       (a_count)
   );

   buf_capture_window #(.NBEATS(4), .SYNC_SYSREF("TRUE")) u_dut_b (
      .aclk          (clk),
      .areset        (areset),
      .capture_i     (capture_b),
      .sysref_i      (sysref_b),
      .delay_i       (delay_b),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (b_s_tready),
      .m_axis_tdata  (b_m_tdata),
      .m_axis_tvalid (b_m_tvalid),
      .m_axis_tready (ready_b),
      .m_axis_tlast  (b_m_tlast),
      .busy_o        (b_busy),
      .overflow_o    (b_overflow),
      .count_o       (b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance to the next cycle; input data always carries the cycle number.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      s_tdata = 128'(cyc);
   endtask

   task automatic goto(input int n);
      while (cyc < n) step();
   endtask

   task automatic push_a(input int c, input int d, input logic l);
      exp_t e;
      e.cyc = c; e.data = 128'(d); e.last = l;
      qa.push_back(e);
   endtask

   task automatic push_b(input int c, input int d, input logic l);
      exp_t e;
      e.cyc = c; e.data = 128'(d); e.last = l;
      qb.push_back(e);
   endtask

   // Monitor for instance A: every handshake must match the head of the queue.
   always @(negedge clk) begin
      if (a_m_tvalid && ready_a) begin
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_beat: got data 0x%0h at cycle %0d, expected no beat", a_m_tdata, cyc);
         end else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_beat_cycle", 128'(cyc), 128'(e.cyc));
            chk("a_beat_data", a_m_tdata, e.data);
            chk("a_beat_last", 128'(a_m_tlast), 128'(e.last));
         end
      end
   end

   // Monitor for instance B.
   always @(negedge clk) begin
      if (b_m_tvalid && ready_b) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_beat: got data 0x%0h at cycle %0d, expected no beat", b_m_tdata, cyc);
         end else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_beat_cycle", 128'(cyc), 128'(e.cyc));
            chk("b_beat_data", b_m_tdata, e.data);
            chk("b_beat_last", 128'(b_m_tlast), 128'(e.last));
         end
      end
   end

   initial begin
      checks = 0; errors = 0; cyc = 0;
      areset = 1'b1; s_tdata = '0; s_tvalid = 1'b1;
      capture_a = 1'b0; delay_a = 16'd0; ready_a = 1'b1;
      capture_b = 1'b0; delay_b = 16'd0; ready_b = 1'b1; sysref_b = 1'b0;

      // Reset values
      goto(3); areset = 1'b0;
      @(negedge clk);
      chk("a_rst_tvalid", 128'(a_m_tvalid), 128'd0);
      chk("a_rst_tlast", 128'(a_m_tlast), 128'd0);
      chk("a_rst_tdata", a_m_tdata, 128'd0);
      chk("a_rst_busy", 128'(a_busy), 128'd0);
      chk("a_rst_count", 128'(a_count), 128'd0);
      chk("a_rst_tready", 128'(a_s_tready), 128'd1);
      chk("b_rst_tvalid", 128'(b_m_tvalid), 128'd0);
      chk("b_rst_overflow", 128'(b_overflow), 128'd0);
      chk("b_rst_tready", 128'(b_s_tready), 128'd1);

      // Unaligned window, delay 0: beats 11..14 at cycles 12..15
      goto(10); capture_a = 1'b1; delay_a = 16'd0;
      push_a(12, 11, 1'b0); push_a(13, 12, 1'b0); push_a(14, 13, 1'b0); push_a(15, 14, 1'b1);
      @(negedge clk); chk("a_busy_capture_cycle", 128'(a_busy), 128'd0);
      goto(11); capture_a = 1'b0;
      @(negedge clk); chk("a_busy_rise", 128'(a_busy), 128'd1);
      goto(15);
      @(negedge clk); chk("a_busy_last_beat", 128'(a_busy), 128'd1);
      goto(16);
      @(negedge clk);
      chk("a_busy_fall", 128'(a_busy), 128'd0);
      chk("a_count_window", 128'(a_count), 128'd4);
      chk("a_overflow_none", 128'(a_overflow), 128'd0);

      // Aligned window, delay 3: edge at capture ignored, edge at 40 aligns, first beat is 44
      goto(20); capture_b = 1'b1; delay_b = 16'd3; sysref_b = 1'b1;
      goto(21); capture_b = 1'b0; sysref_b = 1'b0;
      goto(30);
      @(negedge clk);
      chk("b_busy_armed", 128'(b_busy), 128'd1);
      chk("b_tvalid_armed", 128'(b_m_tvalid), 128'd0);
      goto(40); sysref_b = 1'b1;
      push_b(45, 44, 1'b0); push_b(46, 45, 1'b0); push_b(47, 46, 1'b0); push_b(48, 47, 1'b1);
      goto(41); sysref_b = 1'b0;
      // Re-captures during DELAY and RUN must be ignored
      goto(42); capture_b = 1'b1; delay_b = 16'd0;
      goto(43); capture_b = 1'b0;
      goto(45); capture_b = 1'b1;
      goto(46); capture_b = 1'b0;
      goto(49);
      @(negedge clk);
      chk("b_count_window", 128'(b_count), 128'd4);
      chk("b_busy_fall", 128'(b_busy), 128'd0);
      chk("b_overflow_none", 128'(b_overflow), 128'd0);

      // Stall two cycles in RUN: beats 64,65 dropped, window still ends at beat 66
      goto(60); capture_b = 1'b1; delay_b = 16'd0;
      goto(61); capture_b = 1'b0;
      goto(62); sysref_b = 1'b1;
      goto(63); sysref_b = 1'b0;
      push_b(66, 63, 1'b0); push_b(67, 66, 1'b1);
      goto(64); ready_b = 1'b0;
      goto(65);
      @(negedge clk);
      chk("b_hold_tdata", b_m_tdata, 128'd63);
      chk("b_hold_tvalid", 128'(b_m_tvalid), 128'd1);
      goto(66); ready_b = 1'b1;
      goto(68);
      @(negedge clk);
      chk("b_overflow_set", 128'(b_overflow), 128'd1);
      chk("b_count_after_drop", 128'(b_count), 128'd2);
      chk("b_busy_after_drop", 128'(b_busy), 128'd0);

      // Dropped final beat: held beat 83 leaves with tlast
      goto(80); capture_b = 1'b1; delay_b = 16'd0;
      goto(81); capture_b = 1'b0;
      @(negedge clk);
      chk("b_overflow_cleared", 128'(b_overflow), 128'd0);
      chk("b_count_cleared", 128'(b_count), 128'd0);
      goto(82); sysref_b = 1'b1;
      goto(83); sysref_b = 1'b0;
      push_b(87, 83, 1'b1);
      goto(84); ready_b = 1'b0;
      goto(85);
      @(negedge clk);
      chk("b_hold_tlast_early", 128'(b_m_tlast), 128'd0);
      chk("b_hold_tdata2", b_m_tdata, 128'd83);
      goto(87); ready_b = 1'b1;
      goto(88);
      @(negedge clk);
      chk("b_count_final_drop", 128'(b_count), 128'd1);
      chk("b_overflow_final_drop", 128'(b_overflow), 128'd1);
      chk("b_busy_final_drop", 128'(b_busy), 128'd0);

      // Reset in the middle of a window
      goto(100); capture_b = 1'b1; delay_b = 16'd0;
      goto(101); capture_b = 1'b0;
      goto(102); sysref_b = 1'b1;
      goto(103); sysref_b = 1'b0;
      goto(104); ready_b = 1'b0;
      goto(105);
      @(negedge clk);
      chk("b_pre_reset_overflow", 128'(b_overflow), 128'd1);
      goto(106); areset = 1'b1;
      @(negedge clk);
      chk("b_mid_rst_tvalid", 128'(b_m_tvalid), 128'd0);
      chk("b_mid_rst_tlast", 128'(b_m_tlast), 128'd0);
      chk("b_mid_rst_tdata", b_m_tdata, 128'd0);
      chk("b_mid_rst_busy", 128'(b_busy), 128'd0);
      chk("b_mid_rst_overflow", 128'(b_overflow), 128'd0);
      chk("b_mid_rst_count", 128'(b_count), 128'd0);
      goto(107); areset = 1'b0; ready_b = 1'b1;

      // Full window after reset
      goto(110); capture_b = 1'b1; delay_b = 16'd0;
      goto(111); capture_b = 1'b0;
      goto(112); sysref_b = 1'b1;
      goto(113); sysref_b = 1'b0;
      push_b(114, 113, 1'b0); push_b(115, 114, 1'b0); push_b(116, 115, 1'b0); push_b(117, 116, 1'b1);
      goto(118);
      @(negedge clk);
      chk("b_count_post_reset", 128'(b_count), 128'd4);
      chk("b_busy_post_reset", 128'(b_busy), 128'd0);

      goto(120);
      @(negedge clk);
      chk("a_queue_drained", 128'(qa.size()), 128'd0);
      chk("b_queue_drained", 128'(qb.size()), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
